// File: rtl/ysyx_23060184_ifetch_axi_if.sv
// AXI4 read-address/read-data bus plus arbiter request/grant, as seen by the
// instruction-fetch master.
interface ysyx_23060184_ifetch_axi_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned ID_WIDTH   = 4
);
   logic                  grant;
   logic                  irequest;
   logic [ADDR_WIDTH-1:0] araddr;
   logic                  arvalid;
   logic                  arready;
   logic [ID_WIDTH-1:0]   arid;
   logic [7:0]            arlen;
   logic [2:0]            arsize;
   logic [1:0]            arburst;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rvalid;
   logic                  rlast;
   logic                  rready;

   modport master (
      input  grant, arready, rdata, rresp, rvalid, rlast,
      output irequest, araddr, arvalid, arid, arlen, arsize, arburst, rready
   );

   modport slave (
      output grant, arready, rdata, rresp, rvalid, rlast,
      input  irequest, araddr, arvalid, arid, arlen, arsize, arburst, rready
   );
endinterface

// File: rtl/ysyx_23060184_ifetch_axi.sv
// Instruction fetch unit: one-line fetch buffer refilled by AXI4 INCR bursts,
// with redirect flush (draining any started burst), fence.i invalidate and fault reporting.
module ysyx_23060184_ifetch_axi #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned ID_WIDTH   = 4,
   parameter int unsigned FETCH_ID   = 0,
   parameter int unsigned BURST_LEN  = 4
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [ADDR_WIDTH-1:0] pc,
   input  logic                  pc_valid,
   output logic                  pc_ready,
   output logic [DATA_WIDTH-1:0] inst,
   output logic                  inst_valid,
   input  logic                  inst_ready,
   output logic                  inst_fault,
   input  logic                  flush,
   input  logic                  invalidate,
   ysyx_23060184_ifetch_axi_if.master bus
);

   localparam int unsigned OFF   = $clog2(BURST_LEN) + 2;
   localparam int unsigned IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int unsigned TAG_W = ADDR_WIDTH - OFF;
   localparam logic [IDX_W-1:0] IDX_MASK = IDX_W'(BURST_LEN - 1);

   typedef enum logic [2:0] {StIdle, StReq, StData, StResp, StDrain} state_e;

   state_e                state_q;
   logic [DATA_WIDTH-1:0] line_q [BURST_LEN];
   logic [TAG_W-1:0]      tag_q;
   logic                  line_valid_q;
   logic [IDX_W-1:0]      beat_q;
   logic [IDX_W-1:0]      idx_q;
   logic                  err_q;
   logic                  flush_pend_q;

   logic                  pc_ready_q;
   logic                  inst_valid_q;
   logic                  inst_fault_q;
   logic [DATA_WIDTH-1:0] inst_q;
   logic                  irequest_q;
   logic                  arvalid_q;
   logic                  rready_q;
   logic [ADDR_WIDTH-1:0] araddr_q;

   logic [TAG_W-1:0] pc_tag;
   logic [IDX_W-1:0] pc_idx;
   logic             pc_hit;
   logic             ar_fire;
   logic             beat_fire;
   logic             beat_err;
   logic             unused_pc;

   assign pc_tag    = pc[ADDR_WIDTH-1:OFF];
   assign pc_idx    = pc[IDX_W+1:2] & IDX_MASK;
   assign unused_pc = ^pc[1:0];
   // A same-cycle invalidate wins over a hit.
   assign pc_hit    = line_valid_q && !invalidate && (pc_tag == tag_q);
   assign ar_fire   = bus.grant && arvalid_q && bus.arready;
   assign beat_fire = bus.grant && bus.rvalid && rready_q;
   assign beat_err  = bus.rresp != 2'b00;

   assign pc_ready     = pc_ready_q;
   assign inst         = inst_q;
   assign inst_valid   = inst_valid_q;
   assign inst_fault   = inst_fault_q;
   assign bus.irequest = irequest_q;
   assign bus.araddr   = araddr_q;
   assign bus.arvalid  = arvalid_q;
   assign bus.rready   = rready_q;
   assign bus.arid     = ID_WIDTH'(FETCH_ID);
   assign bus.arlen    = 8'(BURST_LEN - 1);
   assign bus.arsize   = 3'b010;
   assign bus.arburst  = 2'b01;

   always_ff @(posedge clk) begin
      if (resetn && state_q == StData && beat_fire) begin
         line_q[beat_q] <= bus.rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q      <= StIdle;
         tag_q        <= '0;
         line_valid_q <= 1'b0;
         beat_q       <= '0;
         idx_q        <= '0;
         err_q        <= 1'b0;
         flush_pend_q <= 1'b0;
         pc_ready_q   <= 1'b1;
         inst_valid_q <= 1'b0;
         inst_fault_q <= 1'b0;
         inst_q       <= '0;
         irequest_q   <= 1'b0;
         arvalid_q    <= 1'b0;
         rready_q     <= 1'b0;
         araddr_q     <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (pc_valid && !flush) begin
                  idx_q      <= pc_idx;
                  pc_ready_q <= 1'b0;
                  if (pc_hit) begin
                     inst_q       <= line_q[pc_idx];
                     inst_valid_q <= 1'b1;
                     inst_fault_q <= 1'b0;
                     state_q      <= StResp;
                  end else begin
                     araddr_q   <= {pc_tag, {OFF{1'b0}}};
                     arvalid_q  <= 1'b1;
                     irequest_q <= 1'b1;
                     state_q    <= StReq;
                  end
               end
            end
            StReq: begin
               // AR cannot be withdrawn once offered; a flush here only redirects to drain.
               if (ar_fire) begin
                  arvalid_q    <= 1'b0;
                  rready_q     <= 1'b1;
                  line_valid_q <= 1'b0;
                  tag_q        <= araddr_q[ADDR_WIDTH-1:OFF];
                  beat_q       <= '0;
                  err_q        <= 1'b0;
                  flush_pend_q <= 1'b0;
                  state_q      <= (flush || flush_pend_q) ? StDrain : StData;
               end else if (flush) begin
                  flush_pend_q <= 1'b1;
               end
            end
            StData: begin
               if (beat_fire) begin
                  if (beat_q == idx_q) inst_q <= bus.rdata;
                  beat_q <= (beat_q + 1'b1) & IDX_MASK;
                  if (beat_err) err_q <= 1'b1;
               end
               if (beat_fire && bus.rlast) begin
                  beat_q     <= '0;
                  rready_q   <= 1'b0;
                  irequest_q <= 1'b0;
                  if (flush) begin
                     err_q      <= 1'b0;
                     pc_ready_q <= 1'b1;
                     state_q    <= StIdle;
                  end else begin
                     line_valid_q <= !(err_q || beat_err);
                     inst_valid_q <= 1'b1;
                     inst_fault_q <= err_q || beat_err;
                     state_q      <= StResp;
                  end
               end else if (flush) begin
                  err_q   <= 1'b0;
                  beat_q  <= '0;
                  state_q <= StDrain;
               end
            end
            StResp: begin
               if (flush || inst_ready) begin
                  inst_valid_q <= 1'b0;
                  inst_fault_q <= 1'b0;
                  err_q        <= 1'b0;
                  pc_ready_q   <= 1'b1;
                  state_q      <= StIdle;
               end
            end
            StDrain: begin
               if (beat_fire && bus.rlast) begin
                  rready_q   <= 1'b0;
                  irequest_q <= 1'b0;
                  pc_ready_q <= 1'b1;
                  state_q    <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
         if (invalidate) line_valid_q <= 1'b0;
      end
   end

endmodule
